// File: rtl/axi_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter: FSM encodings, sizing limits
// and the rotating priority encoder used to pick the next packet owner.
package axi_arb_pkg;

  localparam int MAX_INPUTS = 8;
  localparam int IDX_W      = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef logic [IDX_W-1:0] idx_t;

  // First set bit of req scanning upward from (last+1) with wrap at n.
  function automatic idx_t rr_pick(input logic [MAX_INPUTS-1:0] req,
                                   input idx_t                  last,
                                   input int                    n);
    idx_t win;
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_INPUTS; i++) begin
      if (i <= n) begin
        idx = int'(last) + i;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (!found && req[idx[IDX_W-1:0]]) begin
          win   = idx[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axi_arb_skid.sv
// Two-entry FIFO-ordered skid stage. s_space depends only on registered occupancy,
// so downstream ready never reaches the upstream ready combinationally.
module axi_arb_skid
  import axi_arb_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_space,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             push, pop;

  assign s_space = (count_q != 2'd2);
  assign m_data  = out_q;
  assign m_valid = valid_q;

  always_comb begin
    push    = s_valid & s_space;
    pop     = valid_q & m_ready;
    count_d = count_q;
    out_d   = out_q;
    hold_d  = hold_q;
    if (push && !pop) begin
      if (count_q == 2'd0) begin
        out_d = s_data;
      end else begin
        hold_d = s_data;
      end
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      if (count_q == 2'd2) begin
        out_d = hold_q;
      end
      count_d = count_q - 2'd1;
    end else if (push && pop) begin
      // Only reachable with one entry: the head leaves and the new beat takes its place.
      out_d = s_data;
    end
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      out_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/axi_packet_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_INPUTS AXI streams into one, via a 2-entry skid.
// Define ARB_PRIO0_EN to give input 0 strict priority at each arbitration point.
module axi_packet_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH      = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_INPUTS*WIDTH-1:0] i_tdata,
  input  logic [NUM_INPUTS-1:0]       i_tlast,
  input  logic [NUM_INPUTS-1:0]       i_tvalid,
  output logic [NUM_INPUTS-1:0]       i_tready,
  output logic [WIDTH-1:0]            o_tdata,
  output logic                        o_tlast,
  output logic                        o_tvalid,
  input  logic                        o_tready,
  output logic [NUM_INPUTS-1:0]       grant,
  output logic                        busy
);

  logic [0:0]            state_q, state_d;
  logic [NUM_INPUTS-1:0] grant_q, grant_d;
  idx_t                  last_q, last_d;

  logic [MAX_INPUTS-1:0] req;
  idx_t                  win;
  logic [WIDTH-1:0]      sel_data;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  space;
  logic                  push;

  // grant_q is zero outside BUSY, so masking by it also gates ready in IDLE.
  assign i_tready = grant_q & {NUM_INPUTS{space}};
  assign grant    = grant_q;
  assign busy     = (state_q == ST_BUSY);
  assign push     = busy & sel_valid & space;

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_q[i]) begin
        sel_data  = i_tdata[i*WIDTH +: WIDTH];
        sel_last  = i_tlast[i];
        sel_valid = i_tvalid[i];
      end
    end
  end

  always_comb begin
    req                   = '0;
    req[NUM_INPUTS-1:0]   = i_tvalid;
`ifdef ARB_PRIO0_EN
    if (i_tvalid[0]) begin
      win = '0;
    end else begin
      win = rr_pick(req, last_q, NUM_INPUTS);
    end
`else
    win = rr_pick(req, last_q, NUM_INPUTS);
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_tvalid) begin
          state_d = ST_BUSY;
          last_d  = win;
          for (int i = 0; i < NUM_INPUTS; i++) begin
            grant_d[i] = (int'(win) == i);
          end
        end
      end
      ST_BUSY: begin
        // Owner keeps the grant through any tvalid gap until its tlast beat is taken.
        if (push && sel_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= idx_t'(NUM_INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  axi_arb_skid #(
    .WIDTH (WIDTH + 1)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .s_data  ({sel_last, sel_data}),
    .s_valid (push),
    .s_space (space),
    .m_data  ({o_tlast, o_tdata}),
    .m_valid (o_tvalid),
    .m_ready (o_tready)
  );

endmodule

// File: tb/tb_axi_packet_rr_arbiter.sv
// Randomized bench for axi_packet_rr_arbiter with a queue-based reference model.
// Define ARB_PRIO0_EN to exercise the input-0 strict-priority build.
module tb_axi_packet_rr_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  typedef logic [W:0] beat_t;

  logic           clk;
  logic           reset_n;
  logic [N*W-1:0] tdata;
  logic [N-1:0]   tl;
  logic [N-1:0]   tv;
  logic [N-1:0]   i_tready;
  logic [W-1:0]   o_tdata;
  logic           o_tlast;
  logic           o_tvalid;
  logic           o_tready_r;
  logic [N-1:0]   grant;
  logic           busy;

  axi_packet_rr_arbiter #(.NUM_INPUTS(N), .WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_tdata  (tdata),
    .i_tlast  (tl),
    .i_tvalid (tv),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready_r),
    .grant    (grant),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Source state.
  bit en[N];
  bit hold[N];
  int budget[N];
  int beat_idx[N];
  int pkt_len[N];
  int seq[N];
  int force_low[N];
  int valid_pct, stall_pct, plen_min, plen_max;

  // Reference model: packet owner, last winner, and the skid contents as a queue.
  bit    m_busy;
  int    m_g;
  int    m_last;
  beat_t mq[$];
  int    served_log[$];
  int    served_cnt[N];

  task automatic chk(input string name, input beat_t act, input beat_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_ready;
    exp_grant = '0;
    exp_ready = '0;
    if (m_busy) begin
      exp_grant[m_g] = 1'b1;
      if (mq.size() < 2) exp_ready[m_g] = 1'b1;
    end
    chk("o_tvalid", beat_t'(o_tvalid), beat_t'(mq.size() > 0));
    if (mq.size() > 0) chk("o_beat", {o_tlast, o_tdata}, mq[0]);
    chk("grant", beat_t'(grant), beat_t'(exp_grant));
    chk("busy", beat_t'(busy), beat_t'(m_busy));
    chk("i_tready", beat_t'(i_tready), beat_t'(exp_ready));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (force_low[i] > 0) begin
        force_low[i]--;
      end else if (!hold[i] && en[i] && budget[i] > 0 &&
                   $urandom_range(99, 0) < valid_pct) begin
        hold[i] = 1'b1;
        if (beat_idx[i] == 0) pkt_len[i] = $urandom_range(plen_max, plen_min);
      end
      tv[i] = hold[i];
      tdata[i*W +: W] = {8'(i + 1), 32'(seq[i]), 24'(beat_idx[i])};
      tl[i] = (beat_idx[i] == pkt_len[i] - 1);
    end
    o_tready_r = ($urandom_range(99, 0) >= stall_pct);
  endtask

  task automatic model_step();
    bit    acc;
    beat_t b;
    acc = 1'b0;
    b   = '0;
    if (m_busy && tv[m_g] && mq.size() < 2) begin
      acc = 1'b1;
      b   = {tl[m_g], tdata[m_g*W +: W]};
    end
    if (mq.size() > 0 && o_tready_r) begin
      if (mq[0][W]) $display("pkt out src=%0d seq=%0d", int'(mq[0][W-1:W-8]) - 1, int'(mq[0][55:24]));
      void'(mq.pop_front());
    end
    if (acc) begin
      mq.push_back(b);
      hold[m_g] = 1'b0;
      if (tl[m_g]) begin
        m_busy = 1'b0;
        served_cnt[m_g]++;
        served_log.push_back(m_g);
        budget[m_g]--;
        beat_idx[m_g] = 0;
        seq[m_g]++;
      end else begin
        beat_idx[m_g]++;
      end
    end else if (!m_busy && tv != '0) begin
      m_g    = pick(tv, m_last);
      m_last = m_g;
      m_busy = 1'b1;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    drive_inputs();
    @(posedge clk);
    #1;
    model_step();
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    tv = '0;
    #1;
    chk("rst_o_tvalid", beat_t'(o_tvalid), 0);
    chk("rst_o_beat", {o_tlast, o_tdata}, 0);
    chk("rst_grant", beat_t'(grant), 0);
    chk("rst_busy", beat_t'(busy), 0);
    chk("rst_i_tready", beat_t'(i_tready), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mq.delete();
    served_log.delete();
    m_busy = 1'b0;
    m_g    = 0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      hold[i] = 1'b0;
      beat_idx[i] = 0;
      seq[i] = 0;
      force_low[i] = 0;
      served_cnt[i] = 0;
      en[i] = 1'b0;
      budget[i] = 0;
      pkt_len[i] = 1;
    end
    cyc = 0;
  endtask

  task automatic setup(input logic [N-1:0] en_mask, input int bud, input int pct,
                       input int stall, input int pmin, input int pmax);
    for (int i = 0; i < N; i++) begin
      en[i] = en_mask[i];
      budget[i] = en_mask[i] ? bud : 0;
    end
    valid_pct = pct;
    stall_pct = stall;
    plen_min  = pmin;
    plen_max  = pmax;
  endtask

  task automatic run_until_served(input int pkts, input int limit, input string name);
    int k;
    k = 0;
    while (served_log.size() < pkts && k < limit) begin
      run_cycle();
      k++;
    end
    chk(name, beat_t'(served_log.size()), beat_t'(pkts));
  endtask

  initial begin
    reset_n = 1'b0;
    tv = '0;
    tl = '0;
    tdata = '0;
    o_tready_r = 1'b1;
    valid_pct = 0;
    stall_pct = 0;
    plen_min = 1;
    plen_max = 1;
    repeat (2) @(posedge clk);
    apply_reset();

    // Inputs 0 and 2, one 3-beat packet each, from cycle 0.
    setup(4'b0101, 1, 100, 0, 3, 3);
    for (int k = 0; k < 12; k++) begin
      run_cycle();
      case (cyc)
        1: begin
          chk("d1_grant_c1", beat_t'(grant), 4'b0001);
          chk("d1_ready_c1", beat_t'(i_tready), 4'b0001);
        end
        2: chk("d1_first_beat", {o_tvalid, o_tdata}, {1'b1, 64'h0100000000000000});
        4: chk("d1_tlast_beat", {o_tlast, o_tdata}, {1'b1, 64'h0100000000000002});
        5: begin
          chk("d1_grant_c5", beat_t'(grant), 4'b0100);
          chk("d1_bubble_c5", beat_t'(o_tvalid), 0);
        end
        6: chk("d1_in2_beat", {o_tvalid, o_tdata}, {1'b1, 64'h0300000000000000});
        default: ;
      endcase
    end
    chk("d1_npkts", beat_t'(served_log.size()), 2);
    if (served_log.size() == 2) begin
      chk("d1_order0", beat_t'(served_log[0]), 0);
      chk("d1_order1", beat_t'(served_log[1]), 2);
    end

    // All inputs continuously valid, 1-beat packets, 100 packets each.
    apply_reset();
    setup(4'b1111, 100, 100, 0, 1, 1);
    run_until_served(400, 2000, "fair_done");
    for (int i = 0; i < N; i++) begin
      chk("fair_share", beat_t'(served_cnt[i] >= 99 && served_cnt[i] <= 101), 1);
    end
`ifndef ARB_PRIO0_EN
    if (served_log.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("rr_order", beat_t'(served_log[i]), beat_t'(i % N));
    end
`endif

    // 8-beat packets with randomly stalled downstream.
    apply_reset();
    setup(4'b0010, 4, 100, 50, 8, 8);
    run_until_served(4, 400, "stall_done");

    // Owner drops tvalid for 5 cycles mid-packet while input 1 waits.
    apply_reset();
    setup(4'b0011, 1, 100, 0, 8, 8);
    for (int k = 0; k < 50 && beat_idx[0] < 2; k++) run_cycle();
    chk("drop_reached", beat_t'(beat_idx[0]), 2);
    force_low[0] = 5;
    repeat (3) run_cycle();
    chk("drop_grant", beat_t'(grant), 4'b0001);
    chk("drop_busy", beat_t'(busy), 1);
    chk("drop_in1_ready", beat_t'(i_tready[1]), 0);
    run_until_served(2, 100, "drop_done");
    if (served_log.size() == 2) chk("drop_order", beat_t'(served_log[1]), 1);

`ifdef ARB_PRIO0_EN
    // Inputs 0 and 1 valid: input 0 keeps winning until it runs dry.
    apply_reset();
    setup(4'b0011, 5, 100, 0, 2, 2);
    run_until_served(10, 200, "prio_done");
    if (served_log.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("prio_order", beat_t'(served_log[i]), beat_t'(i < 5 ? 0 : 1));
    end
`endif

    // Random traffic.
    apply_reset();
    setup(4'b1111, 10000, 70, 30, 1, 8);
    repeat (3000) run_cycle();
    for (int k = 0; k < 200 && !(m_busy && beat_idx[m_g] > 0); k++) run_cycle();
    chk("midpkt_reached", beat_t'(m_busy && beat_idx[m_g] > 0), 1);

    // Reset mid-packet: outputs clear immediately, input 0 wins next.
    apply_reset();
    setup(4'b1111, 10, 100, 0, 1, 4);
    run_cycle();
    chk("post_rst_grant", beat_t'(grant), 4'b0001);
    repeat (100) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
